// File: rtl/wisc_shift_pkg.sv
// Shared definitions for the WISC multi-cycle shift/rotate unit.
// Holds the operation encodings, the sequencer state encodings and the
// default datapath sizes. The shift unit and the EX-stage decoder both
// import this package, so an opcode has one encoding everywhere.
// No ports (package).
package wisc_shift_pkg;

    localparam int SHIFT_WIDTH = 16;
    localparam int SHIFT_CNT_W = 4;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRA = 2'b01,
        OP_ROR = 2'b10,
        OP_ROL = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } shift_state_t;

endpackage

// File: rtl/seq_shift_unit_if.sv
// Request/response bundle between the ALU issue logic and the
// multi-cycle shift unit.
// Signals:
//   start   - request; only acted on while the unit is idle
//   op      - operation code (see wisc_shift_pkg::shift_op_t)
//   data_in - operand, captured together with start
//   amt     - shift/rotate amount, captured together with start
//   busy    - unit is working and will ignore start
//   done    - one-cycle pulse marking a valid result
//   result  - operand register contents
//   zero    - result is all zeros
// The master modport is the requester; the slave modport is the shift unit.
interface seq_shift_unit_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) ();

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] data_in;
    logic [CNT_W-1:0] amt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output start, op, data_in, amt,
        input  busy, done, result, zero
    );

    modport slave (
        input  start, op, data_in, amt,
        output busy, done, result, zero
    );

endinterface

// File: rtl/shift_step.sv
// One-bit shift/rotate step.
// Ports:
//   r      (in,  WIDTH) current register value
//   op     (in,  2)     operation code
//   r_next (out, WIDTH) value after moving one bit position
// Purely combinational; the sequencer applies it once per cycle.
module shift_step
    import wisc_shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH
) (
    input  logic [WIDTH-1:0] r,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] r_next
);

    always_comb begin
        r_next = r;
        case (shift_op_t'(op))
            OP_SLL: r_next = {r[WIDTH-2:0], 1'b0};
            OP_SRA: r_next = {r[WIDTH-1], r[WIDTH-1:1]};
            OP_ROR: r_next = {r[0], r[WIDTH-1:1]};
            OP_ROL: r_next = {r[WIDTH-2:0], r[WIDTH-1]};
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: SLL, SRA, ROR and ROL, one bit per clock.
// Ports:
//   clk (in)  system clock, rising edge
//   rst (in)  asynchronous active-high reset
//   bus (slave modport of seq_shift_unit_if): start/op/data_in/amt in,
//       busy/done/result/zero out
// An accepted start loads the operand, amount and op; the register is then
// stepped once per SHIFT cycle until the count runs out, and done pulses
// for one cycle. result is the register itself and stays put until the
// next accepted start.
module seq_shift_unit
    import wisc_shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int CNT_W = SHIFT_CNT_W
) (
    input logic           clk,
    input logic           rst,
    seq_shift_unit_if.slave bus
);

    shift_state_t     state;
    shift_state_t     state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] step_value;
    logic [CNT_W-1:0] count;
    logic [1:0]       op_q;
    logic             accept;

    // A start is only taken while idle; anything arriving in SHIFT or DONE is dropped.
    assign accept = (state == IDLE) && bus.start;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .r      (shift_reg),
        .op     (op_q),
        .r_next (step_value)
    );

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A zero amount skips SHIFT entirely, so SHIFT is
    // never entered with a zero count and the decrement cannot wrap.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (count == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand register, remaining count and latched op. These are only
    // written on acceptance or while shifting, so input changes after
    // acceptance have no effect and the result holds after done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            count     <= '0;
            op_q      <= OP_SLL;
        end else if (accept) begin
            shift_reg <= bus.data_in;
            count     <= bus.amt;
            op_q      <= bus.op;
        end else if (state == SHIFT) begin
            shift_reg <= step_value;
            count     <= count - CNT_W'(1);
        end
    end

    // Status outputs come straight from registered state, so they carry no
    // combinational path from the request inputs.
    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.result = shift_reg;
    assign bus.zero   = (shift_reg == '0);

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit. Expected results come from a
// whole-amount reference model (shift/rotate by amt in one expression),
// not from iterating single-bit steps.
module tb_seq_shift_unit;

    logic clk;
    logic rst;
    int   checkCount;
    int   passCount;

    seq_shift_unit_if #(.WIDTH(16), .CNT_W(4)) bus ();

    seq_shift_unit #(.WIDTH(16), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something stalls outside the bounded loops.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: the whole operation in one step.
    function automatic logic [15:0] refModel(input logic [1:0] o, input logic [15:0] d,
                                             input logic [3:0] a);
        logic [31:0]        pair;
        logic signed [15:0] s;
        logic [15:0]        res;
        pair = {d, d};
        s    = d;
        case (o)
            2'b00: res = d << a;
            2'b01: res = s >>> a;
            2'b10: begin pair = pair >> a; res = pair[15:0]; end
            default: begin pair = pair << a; res = pair[31:16]; end
        endcase
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", tag, actual, expected);
        end else begin
            passCount++;
        end
    endtask

    // Issue one operation, scramble the inputs after acceptance, and check
    // latency, result, zero flag, pulse width and result hold.
    task automatic applyStimulus(input logic [1:0] o, input logic [15:0] d, input logic [3:0] a);
        logic [15:0] expVal;
        int          lat;
        bit          seen;
        expVal = refModel(o, d, a);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = o;
        bus.data_in = d;
        bus.amt     = a;
        @(posedge clk);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.op      = 2'($urandom);
        bus.data_in = 16'($urandom);
        bus.amt     = 4'($urandom);
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.done) begin
                seen = 1'b1;
                lat  = k;
                break;
            end
            @(negedge clk);
        end
        checkOutput("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            checkOutput("latency", 32'(lat), 32'(a) + 32'd1);
            checkOutput("result", 32'(bus.result), 32'(expVal));
            checkOutput("zero", 32'(bus.zero), 32'(expVal == 16'h0));
            checkOutput("busy_in_done", 32'(bus.busy), 32'd1);
            @(negedge clk);
            checkOutput("done_width", 32'(bus.done), 32'd0);
            checkOutput("idle_busy", 32'(bus.busy), 32'd0);
            checkOutput("result_hold", 32'(bus.result), 32'(expVal));
        end
    endtask

    initial begin
        int          doneCount;
        logic [15:0] firstData;
        logic [15:0] heldResult;
        checkCount  = 0;
        passCount   = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.data_in = 16'h0;
        bus.amt     = 4'h0;
        #12;
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_result", 32'(bus.result), 32'd0);
        checkOutput("rst_zero", 32'(bus.zero), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        applyStimulus(2'b11, 16'h8001, 4'd1);
        checkOutput("rol_value", 32'(bus.result), 32'h0003);
        applyStimulus(2'b10, 16'h0001, 4'd4);
        checkOutput("ror_value", 32'(bus.result), 32'h1000);
        applyStimulus(2'b01, 16'h8000, 4'd15);
        checkOutput("sra_value", 32'(bus.result), 32'hFFFF);
        applyStimulus(2'b00, 16'h0001, 4'd15);
        checkOutput("sll_value", 32'(bus.result), 32'h8000);
        applyStimulus(2'b00, 16'h1234, 4'd0);
        checkOutput("amt0_value", 32'(bus.result), 32'h1234);
        applyStimulus(2'b00, 16'h0000, 4'd0);
        checkOutput("amt0_zero", 32'(bus.zero), 32'd1);

        // Rotate-right over every amount on random data.
        for (int a = 0; a < 16; a++) begin
            applyStimulus(2'b10, 16'($urandom), 4'(a));
        end

        // Busy lockout: extra starts in SHIFT and in DONE are dropped.
        firstData = 16'($urandom) | 16'h0100;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = 2'b11;
        bus.data_in = firstData;
        bus.amt     = 4'd8;
        @(posedge clk);
        doneCount  = 0;
        heldResult = 16'h0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.done) begin
                doneCount++;
                heldResult = bus.result;
                checkOutput("lock_done_cycle", 32'(k), 32'd9);
            end
            bus.start   = (k == 3) || (k == 9);
            bus.data_in = 16'hFFFF;
        end
        bus.start = 1'b0;
        checkOutput("lock_done_count", 32'(doneCount), 32'd1);
        checkOutput("lock_result", 32'(heldResult), 32'(refModel(2'b11, firstData, 4'd8)));
        checkOutput("lock_final", 32'(bus.result), 32'(refModel(2'b11, firstData, 4'd8)));

        // Held start: a new op every amt+2 cycles.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = 2'b00;
        bus.data_in = 16'h00F3;
        bus.amt     = 4'd2;
        @(posedge clk);
        doneCount = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (bus.done) doneCount++;
        end
        bus.start = 1'b0;
        checkOutput("held_start_dones", 32'(doneCount), 32'd4);
        checkOutput("held_start_result", 32'(bus.result), 32'h03CC);
        repeat (4) @(negedge clk);

        // Asynchronous reset in the middle of a long SLL.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = 2'b00;
        bus.data_in = 16'($urandom) | 16'h0001;
        bus.amt     = 4'd10;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_done", 32'(bus.done), 32'd0);
        checkOutput("abort_result", 32'(bus.result), 32'd0);
        checkOutput("abort_zero", 32'(bus.zero), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        doneCount = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (bus.done) doneCount++;
        end
        checkOutput("abort_no_done", 32'(doneCount), 32'd0);
        applyStimulus(2'b01, 16'hA5A5, 4'd3);

        // Random operations.
        for (int i = 0; i < 30; i++) begin
            applyStimulus(2'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
- Multi-cycle shift/rotate unit for the WISC datapath; companion to the single-cycle combinational rotate-right.
- Supplies the left-direction operations (SLL, ROL) plus SRA and ROR.
- Moves one bit position per clock under a start/busy/done handshake, so the ALU issue logic can offload long shifts without a wide barrel network.
- Sits beside the ALU in EX; the result is written back through the normal ALU result mux when done pulses.

Parameters:
- WIDTH, 16, datapath width in bits.
- CNT_W, 4, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  operation: 00 SLL, 01 SRA, 10 ROR, 11 ROL.
- data_in  input  WIDTH  operand; captured with start.
- amt  input  CNT_W  shift/rotate amount, 0..WIDTH-1; captured with start.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  operand register; holds its value until the next accepted start.
- zero  output  1  high when result == 0; valid whenever done is high.

Behaviour:
- Reset (async, active-high) values: state=IDLE, shift register=0, count=0, latched op=00, busy=0, done=0, result=0, zero=1.
- Reset asserted mid-operation aborts the operation immediately. No done is produced for it.
- FSM states:
  - IDLE: if start=1, load register=data_in, count=amt, op_q=op.
    - amt==0: next state DONE.
    - otherwise: next state SHIFT.
  - SHIFT: each cycle, register <= step(register, op_q) and count <= count-1.
    - When count==1, next state DONE; otherwise remain in SHIFT.
  - DONE: done=1 for exactly this cycle; next state IDLE unconditionally.
- Step function, one bit per cycle:
  - SLL: {r[WIDTH-2:0],0}.
  - SRA: {r[WIDTH-1],r[WIDTH-1:1]}.
  - ROR: {r[0],r[WIDTH-1:1]}.
  - ROL: {r[WIDTH-2:0],r[WIDTH-1]}.
- Latency:
  - The edge that accepts start is edge 0.
  - done is high during cycle amt+1 after that edge.
  - amt=0 gives done in the very next cycle, with result=data_in.
- Handshake rules:
  - start is ignored while busy=1 (SHIFT or DONE). It is not queued.
  - start in IDLE is accepted even if it is held across several cycles. Each IDLE cycle with start=1 begins a new operation.
  - Back-to-back operation: start may be asserted in the cycle where done=1, but it is only accepted on the following IDLE cycle. Minimum issue interval is amt+2 cycles.
- busy and done are decoded from registered state (glitch-free, no combinational path from inputs).
- result is the register itself. It is stable from the done cycle until the next accepted start. It changes every cycle during SHIFT and must not be consumed then.
- Maximum amount: amt=WIDTH-1 (15) runs 15 SHIFT cycles. Count arithmetic is unsigned CNT_W bits and never wraps, because SHIFT is never entered with count 0.
- op_q and count are not affected by input changes after acceptance.

Decomposition:
- Shared package wisc_shift_pkg:
  - Op encodings: OP_SLL=2'b00, OP_SRA=2'b01, OP_ROR=2'b10, OP_ROL=2'b11.
  - FSM state encodings: IDLE, SHIFT, DONE (2 bits).
  - Imported by this block and by the EX-stage decoder.
- One combinational sub-module, shift_step: inputs r[WIDTH], op[2]; output r_next[WIDTH]. This keeps the one-bit step unit-testable and reusable.
- FSM, counter and register stay in seq_shift_unit.

Test Plan:
- ROL: op=11, data_in=0x8001, amt=1, start for 1 cycle -> busy high; done pulses 2 cycles after accept; result=0x0003, zero=0.
- ROR: op=10, data_in=0x0001, amt=4 -> done on cycle 5; result=0x1000. Cross-check against the combinational rotate-right for all 16 amounts on random data.
- SRA: op=01, data_in=0x8000, amt=15 -> done on cycle 16; result=0xFFFF. Then SLL: op=00, data_in=0x0001, amt=15 -> result=0x8000.
- Zero amount: op=00, data_in=0x1234, amt=0 -> done next cycle, result=0x1234. Separately, op=00, data_in=0x0000, amt=0 -> zero=1.
- Busy lockout: start an ROL, amt=8, then pulse start with data_in=0xFFFF on cycles 3 and 9 -> both ignored; result matches the first operation only; done pulses exactly once.
- Reset mid-op: assert rst asynchronously (between clock edges) at cycle 4 of an SLL with amt=10 -> busy, done and result go to 0 immediately, zero=1. After release, no done appears, and a new start operates normally.
